// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer for the duck-shooting VGA game: IDLE/WAIT/GAME/PAUSE/SCORE flow,
// per-round seconds timer, multi-round play, pixel source select and play-button geometry.
module game_flow_ctrl #(
    parameter int TICKS_PER_SEC = 65000000,
    parameter int GAME_TIME     = 15,
    parameter int N_ROUNDS      = 1,
    parameter int TIME_W        = 8,
    parameter int COLOR_W       = 12,
    parameter int BTN_X         = 492,
    parameter int BTN_Y         = 376,
    parameter int BTN_W         = 300,
    parameter int BTN_H         = 100
) (
    input  logic               pclk,
    input  logic               rst_d,
    input  logic               mode_multi,
    input  logic               rect_clicked_play,
    input  logic               uart_start,
    input  logic               mouse_clicked_stop,
    input  logic               pause_toggle,
    input  logic [COLOR_W-1:0] rgb_in_play,
    input  logic [COLOR_W-1:0] rgb_in_wait,
    input  logic [COLOR_W-1:0] rgb_in_game,
    input  logic [COLOR_W-1:0] rgb_in_score,
    output logic [COLOR_W-1:0] rgb_out,
    output logic [2:0]         state,
    output logic [10:0]        btn_hstart,
    output logic [10:0]        btn_vstart,
    output logic [10:0]        btn_hlength,
    output logic [10:0]        btn_vlength,
    output logic [TIME_W-1:0]  time_left,
    output logic [3:0]         round_num,
    output logic               game_end
);

    localparam int                 TICK_W     = $clog2(TICKS_PER_SEC);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(GAME_TIME);
    localparam logic [3:0]         ROUND_LAST = 4'(N_ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_GAME  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_SCORE = 3'd4
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [TICK_W-1:0]   tick_r, tick_nxt_s;
    logic [TIME_W-1:0]   time_r, time_nxt_s;
    logic [3:0]          round_r, round_nxt_s;
    logic                end_r, end_nxt_s;
    logic [COLOR_W-1:0]  rgb_r, rgb_nxt_s;
    logic [10:0]         btn_x_r, btn_y_r, btn_w_r, btn_h_r;
    logic                wrap_s;

    assign wrap_s = (tick_r == TICK_LAST);

    // Next-state, timer and pixel-source selection for the current state
    always_comb begin
        state_nxt_s = state_r;
        tick_nxt_s  = tick_r;
        time_nxt_s  = time_r;
        round_nxt_s = round_r;
        end_nxt_s   = 1'b0;
        rgb_nxt_s   = {COLOR_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                rgb_nxt_s = rgb_in_play;
                if (rect_clicked_play) begin
                    state_nxt_s = mode_multi ? ST_WAIT : ST_GAME;
                    round_nxt_s = 4'd1;
                    time_nxt_s  = TIME_INIT;
                    tick_nxt_s  = {TICK_W{1'b0}};
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                rgb_nxt_s = rgb_in_wait;
                if (uart_start) begin
                    state_nxt_s = ST_GAME;
                end else if (mouse_clicked_stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_GAME: begin
                rgb_nxt_s = rgb_in_game;
                // A round end swallows a coincident pause request
                if (wrap_s && (time_r == TIME_W'(1))) begin
                    tick_nxt_s = {TICK_W{1'b0}};
                    if (round_r == ROUND_LAST) begin
                        state_nxt_s = ST_SCORE;
                        time_nxt_s  = {TIME_W{1'b0}};
                        end_nxt_s   = 1'b1;
                    end else begin
                        round_nxt_s = round_r + 4'd1;
                        time_nxt_s  = TIME_INIT;
                    end
                end else begin
                    if (wrap_s) begin
                        tick_nxt_s = {TICK_W{1'b0}};
                        time_nxt_s = time_r - TIME_W'(1);
                    end else begin
                        tick_nxt_s = tick_r + TICK_W'(1);
                    end
                    state_nxt_s = pause_toggle ? ST_PAUSE : ST_GAME;
                end
            end
            ST_PAUSE: begin
                rgb_nxt_s = rgb_in_wait;
                if (mouse_clicked_stop) begin
                    state_nxt_s = ST_IDLE;
                    time_nxt_s  = TIME_INIT;
                end else if (pause_toggle) begin
                    state_nxt_s = ST_GAME;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_SCORE: begin
                rgb_nxt_s = rgb_in_score;
                if (mouse_clicked_stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SCORE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                tick_nxt_s  = {TICK_W{1'b0}};
                time_nxt_s  = TIME_INIT;
                round_nxt_s = 4'd0;
                rgb_nxt_s   = {COLOR_W{1'b0}};
            end
        endcase
    end

    // State and output registers; button geometry follows the state being entered
    always_ff @(posedge pclk or posedge rst_d) begin
        if (rst_d) begin
            state_r <= ST_IDLE;
            tick_r  <= {TICK_W{1'b0}};
            time_r  <= TIME_INIT;
            round_r <= 4'd0;
            end_r   <= 1'b0;
            rgb_r   <= {COLOR_W{1'b0}};
            btn_x_r <= 11'(BTN_X);
            btn_y_r <= 11'(BTN_Y);
            btn_w_r <= 11'(BTN_W);
            btn_h_r <= 11'(BTN_H);
        end else begin
            state_r <= state_nxt_s;
            tick_r  <= tick_nxt_s;
            time_r  <= time_nxt_s;
            round_r <= round_nxt_s;
            end_r   <= end_nxt_s;
            rgb_r   <= rgb_nxt_s;
            btn_x_r <= (state_nxt_s == ST_IDLE) ? 11'(BTN_X) : 11'd0;
            btn_y_r <= (state_nxt_s == ST_IDLE) ? 11'(BTN_Y) : 11'd0;
            btn_w_r <= (state_nxt_s == ST_IDLE) ? 11'(BTN_W) : 11'd0;
            btn_h_r <= (state_nxt_s == ST_IDLE) ? 11'(BTN_H) : 11'd0;
        end
    end

    assign state       = state_r;
    assign rgb_out     = rgb_r;
    assign time_left   = time_r;
    assign round_num   = round_r;
    assign game_end    = end_r;
    assign btn_hstart  = btn_x_r;
    assign btn_vstart  = btn_y_r;
    assign btn_hlength = btn_w_r;
    assign btn_vlength = btn_h_r;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with a short 4-tick second, 3-second rounds and 2 rounds.
module tb_game_flow_ctrl;

    logic        pclk = 1'b0;
    logic        rst_d;
    logic        mode_multi, rect_clicked_play, uart_start, mouse_clicked_stop, pause_toggle;
    logic [11:0] rgb_in_play, rgb_in_wait, rgb_in_game, rgb_in_score, rgb_out;
    logic [2:0]  state;
    logic [10:0] btn_hstart, btn_vstart, btn_hlength, btn_vlength;
    logic [7:0]  time_left;
    logic [3:0]  round_num;
    logic        game_end;

    int vec_cnt = 0;
    int err_cnt = 0;

    game_flow_ctrl #(
        .TICKS_PER_SEC(4),
        .GAME_TIME(3),
        .N_ROUNDS(2)
    ) dut (
        .pclk(pclk),
        .rst_d(rst_d),
        .mode_multi(mode_multi),
        .rect_clicked_play(rect_clicked_play),
        .uart_start(uart_start),
        .mouse_clicked_stop(mouse_clicked_stop),
        .pause_toggle(pause_toggle),
        .rgb_in_play(rgb_in_play),
        .rgb_in_wait(rgb_in_wait),
        .rgb_in_game(rgb_in_game),
        .rgb_in_score(rgb_in_score),
        .rgb_out(rgb_out),
        .state(state),
        .btn_hstart(btn_hstart),
        .btn_vstart(btn_vstart),
        .btn_hlength(btn_hlength),
        .btn_vlength(btn_vlength),
        .time_left(time_left),
        .round_num(round_num),
        .game_end(game_end)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_btn(input string tag, input logic idle);
        chk({tag, "_hs"}, 32'(btn_hstart),  idle ? 32'd492 : 32'd0);
        chk({tag, "_vs"}, 32'(btn_vstart),  idle ? 32'd376 : 32'd0);
        chk({tag, "_hl"}, 32'(btn_hlength), idle ? 32'd300 : 32'd0);
        chk({tag, "_vl"}, 32'(btn_vlength), idle ? 32'd100 : 32'd0);
    endtask

    task automatic do_reset();
        rst_d = 1'b1;
        cyc();
        rst_d = 1'b0;
        cyc();
    endtask

    initial begin
        rst_d = 1'b1;
        mode_multi = 1'b0; rect_clicked_play = 1'b0; uart_start = 1'b0;
        mouse_clicked_stop = 1'b0; pause_toggle = 1'b0;
        rgb_in_play = 12'h5A5; rgb_in_wait = 12'h777;
        rgb_in_game = 12'hABC; rgb_in_score = 12'h123;
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_rgb", 32'(rgb_out), 32'd0);
        chk("rst_time", 32'(time_left), 32'd3);
        chk("rst_round", 32'(round_num), 32'd0);
        chk("rst_end", 32'(game_end), 32'd0);
        chk_btn("rst_btn", 1'b1);
        do_reset();
        chk("idle_rgb", 32'(rgb_out), 32'h5A5);

        // single-player start
        rect_clicked_play = 1'b1;
        cyc();
        rect_clicked_play = 1'b0;
        chk("start_state", 32'(state), 32'd2);
        chk("start_round", 32'(round_num), 32'd1);
        chk("start_time", 32'(time_left), 32'd3);
        chk_btn("start_btn", 1'b0);

        // two full rounds, checked every cycle
        for (int k = 1; k <= 25; k++) begin
            cyc();
            if (k < 24) begin
                chk($sformatf("g_state_%0d", k), 32'(state), 32'd2);
                chk($sformatf("g_time_%0d", k), 32'(time_left), 32'(3 - ((k % 12) / 4)));
                chk($sformatf("g_round_%0d", k), 32'(round_num), (k < 12) ? 32'd1 : 32'd2);
                chk($sformatf("g_end_%0d", k), 32'(game_end), 32'd0);
                chk($sformatf("g_rgb_%0d", k), 32'(rgb_out), 32'hABC);
            end else begin
                chk($sformatf("s_state_%0d", k), 32'(state), 32'd4);
                chk($sformatf("s_time_%0d", k), 32'(time_left), 32'd0);
                chk($sformatf("s_round_%0d", k), 32'(round_num), 32'd2);
                chk($sformatf("s_end_%0d", k), 32'(game_end), (k == 24) ? 32'd1 : 32'd0);
                chk($sformatf("s_rgb_%0d", k), 32'(rgb_out), (k == 24) ? 32'hABC : 32'h123);
            end
        end

        mouse_clicked_stop = 1'b1;
        cyc();
        mouse_clicked_stop = 1'b0;
        chk("score_exit", 32'(state), 32'd0);
        chk("score_exit_time", 32'(time_left), 32'd0);
        chk("score_exit_round", 32'(round_num), 32'd2);
        chk_btn("score_exit_btn", 1'b1);

        // two-player: cancel, then start with coincident uart_start/stop
        mode_multi = 1'b1;
        rect_clicked_play = 1'b1;
        cyc();
        rect_clicked_play = 1'b0;
        chk("wait_state", 32'(state), 32'd1);
        chk("wait_round", 32'(round_num), 32'd1);
        chk("wait_time", 32'(time_left), 32'd3);
        chk_btn("wait_btn", 1'b0);
        pause_toggle = 1'b1;
        cyc();
        pause_toggle = 1'b0;
        chk("wait_pause_ign", 32'(state), 32'd1);
        chk("wait_rgb", 32'(rgb_out), 32'h777);
        mouse_clicked_stop = 1'b1;
        cyc();
        mouse_clicked_stop = 1'b0;
        chk("cancel_state", 32'(state), 32'd0);
        chk_btn("cancel_btn", 1'b1);
        rect_clicked_play = 1'b1;
        cyc();
        rect_clicked_play = 1'b0;
        chk("wait2_state", 32'(state), 32'd1);
        uart_start = 1'b1;
        mouse_clicked_stop = 1'b1;
        cyc();
        uart_start = 1'b0;
        mouse_clicked_stop = 1'b0;
        chk("uart_wins", 32'(state), 32'd2);
        chk_btn("uart_btn", 1'b0);
        mode_multi = 1'b0;

        // pause at time_left=2, tick=1
        repeat (5) cyc();
        chk("pre_pause_time", 32'(time_left), 32'd2);
        pause_toggle = 1'b1;
        cyc();
        pause_toggle = 1'b0;
        chk("pause_state", 32'(state), 32'd3);
        chk("pause_time", 32'(time_left), 32'd2);
        repeat (50) cyc();
        chk("pause_hold_state", 32'(state), 32'd3);
        chk("pause_hold_time", 32'(time_left), 32'd2);
        chk("pause_rgb", 32'(rgb_out), 32'h777);
        pause_toggle = 1'b1;
        cyc();
        pause_toggle = 1'b0;
        chk("resume_state", 32'(state), 32'd2);
        chk("resume_time0", 32'(time_left), 32'd2);
        cyc();
        chk("resume_time1", 32'(time_left), 32'd2);
        cyc();
        chk("resume_time2", 32'(time_left), 32'd1);
        mouse_clicked_stop = 1'b1;
        cyc();
        mouse_clicked_stop = 1'b0;
        chk("game_stop_ign", 32'(state), 32'd2);

        // asynchronous reset between clock edges
        @(negedge pclk);
        rst_d = 1'b1;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_rgb", 32'(rgb_out), 32'd0);
        chk("arst_time", 32'(time_left), 32'd3);
        chk("arst_round", 32'(round_num), 32'd0);
        chk_btn("arst_btn", 1'b1);
        cyc();
        rst_d = 1'b0;
        cyc();

        // pause coinciding with round end is dropped
        rect_clicked_play = 1'b1;
        cyc();
        rect_clicked_play = 1'b0;
        repeat (11) cyc();
        chk("pre_end_time", 32'(time_left), 32'd1);
        pause_toggle = 1'b1;
        cyc();
        pause_toggle = 1'b0;
        chk("end_pause_state", 32'(state), 32'd2);
        chk("end_pause_round", 32'(round_num), 32'd2);
        chk("end_pause_time", 32'(time_left), 32'd3);

        // abort wins over resume in PAUSE
        pause_toggle = 1'b1;
        cyc();
        pause_toggle = 1'b0;
        chk("pause2_state", 32'(state), 32'd3);
        pause_toggle = 1'b1;
        mouse_clicked_stop = 1'b1;
        cyc();
        pause_toggle = 1'b0;
        mouse_clicked_stop = 1'b0;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_time", 32'(time_left), 32'd3);
        chk("abort_round", 32'(round_num), 32'd2);
        chk_btn("abort_btn", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
